// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared size encodings, FSM state type and store lane helpers
package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    // Byte write enables for a store; size 11 behaves as a word.
    function automatic logic [3:0] store_wen(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SZ_BYTE: store_wen = 4'b0001 << addr_lo;
            SZ_HALF: store_wen = addr_lo[1] ? 4'b1100 : 4'b0011;
            default: store_wen = 4'b1111;
        endcase
    endfunction

    // Replicate right-justified store data across every lane so wen alone picks the target.
    function automatic logic [31:0] store_wdata(input logic [1:0] size, input logic [31:0] wdata);
        case (size)
            SZ_BYTE: store_wdata = {4{wdata[7:0]}};
            SZ_HALF: store_wdata = {2{wdata[15:0]}};
            default: store_wdata = wdata;
        endcase
    endfunction

    // Half on an odd byte, or word off a word boundary.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SZ_BYTE: misaligned = 1'b0;
            SZ_HALF: misaligned = addr_lo[0];
            default: misaligned = (addr_lo != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/load_align.sv
// rtl/load_align.sv - selects the addressed load lane and sign/zero-extends it
module load_align
    import mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] data
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    assign byte_lane = rdata[{addr_lo, 3'b000} +: 8];
    assign half_lane = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    // Extend the selected lane; sign bit is forced low for unsigned loads.
    always_comb begin
        data = rdata;
        case (size)
            SZ_BYTE: data = {{24{~is_unsigned & byte_lane[7]}}, byte_lane};
            SZ_HALF: data = {{16{~is_unsigned & half_lane[15]}}, half_lane};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/data_sram_ctrl.sv
// rtl/data_sram_ctrl.sv - MEM-stage data SRAM controller; DSRAM_ALIGN_CHECK_EN enables misalignment errors
module data_sram_ctrl
    import mem_pkg::*;
#(
    parameter int RD_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        data_sram_en,
    output logic [3:0]  data_sram_wen,
    output logic [31:0] data_sram_addr,
    output logic [31:0] data_sram_wdata,
    input  logic [31:0] data_sram_rdata
);

    localparam logic [1:0] LAT_LAST = 2'(RD_LATENCY - 1);

    state_t      state;
    logic [1:0]  lat_cnt;
    logic        we_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [1:0]  addr_lo_q;
    logic        en_q;
    logic [3:0]  wen_q;
    logic [31:0] sram_addr_q;
    logic [31:0] sram_wdata_q;
    logic        resp_valid_q;
    logic [31:0] load_data;
`ifdef DSRAM_ALIGN_CHECK_EN
    logic        resp_err_q;
`endif

    // Request FSM; SRAM and response controls are registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            lat_cnt      <= 2'd0;
            we_q         <= 1'b0;
            size_q       <= SZ_BYTE;
            uns_q        <= 1'b0;
            addr_lo_q    <= 2'b00;
            en_q         <= 1'b0;
            wen_q        <= 4'b0000;
            sram_addr_q  <= 32'd0;
            sram_wdata_q <= 32'd0;
            resp_valid_q <= 1'b0;
`ifdef DSRAM_ALIGN_CHECK_EN
            resp_err_q   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        we_q      <= req_we;
                        size_q    <= req_size;
                        uns_q     <= req_unsigned;
                        addr_lo_q <= req_addr[1:0];
`ifdef DSRAM_ALIGN_CHECK_EN
                        if (misaligned(req_size, req_addr[1:0])) begin
                            state        <= RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                        end else
`endif
                        begin
                            state        <= ACCESS;
                            lat_cnt      <= 2'd0;
                            en_q         <= 1'b1;
                            wen_q        <= req_we ? store_wen(req_size, req_addr[1:0]) : 4'b0000;
                            sram_addr_q  <= {req_addr[31:2], 2'b00};
                            sram_wdata_q <= req_we ? store_wdata(req_size, req_wdata) : 32'd0;
                        end
                    end
                end
                ACCESS: begin
                    // A store writes once; later cycles only hold the address.
                    wen_q <= 4'b0000;
                    if (lat_cnt == LAT_LAST) begin
                        state        <= RESP;
                        en_q         <= 1'b0;
                        sram_addr_q  <= 32'd0;
                        sram_wdata_q <= 32'd0;
                        resp_valid_q <= 1'b1;
                    end else begin
                        lat_cnt <= lat_cnt + 2'd1;
                    end
                end
                RESP: begin
                    state        <= IDLE;
                    resp_valid_q <= 1'b0;
`ifdef DSRAM_ALIGN_CHECK_EN
                    resp_err_q   <= 1'b0;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

    load_align u_load_align (
        .rdata       (data_sram_rdata),
        .addr_lo     (addr_lo_q),
        .size        (size_q),
        .is_unsigned (uns_q),
        .data        (load_data)
    );

    // Handshake and strobes are masked by rst so nothing leaks during the reset cycle.
    assign req_ready       = (state == IDLE) && !rst;
    assign data_sram_en    = en_q && !rst;
    assign data_sram_wen   = rst ? 4'b0000 : wen_q;
    assign data_sram_addr  = sram_addr_q;
    assign data_sram_wdata = sram_wdata_q;
    assign resp_valid      = resp_valid_q && !rst;

`ifdef DSRAM_ALIGN_CHECK_EN
    assign resp_err = resp_err_q && !rst;
`else
    assign resp_err = 1'b0;
`endif

    assign resp_rdata = (resp_valid && !we_q && !resp_err) ? load_data : 32'd0;

endmodule
